// File: rtl/instr_sequencer.sv
// ============================================================================
// instr_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Generates the timestep T and the instruction-fetch handshake for the
//   10-bit processor controller. Each instruction is fetched from program
//   memory, then T steps 1,2,3 until the controller raises Clr. An encoding
//   that never raises Clr is aborted at T=3 and flagged as illegal (sticky).
//   Supports free-run (run level) and single-step (step rising edge) modes.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   run          in   free-run mode while high
//   step         in   debounced button level; rising edge runs one instruction
//   Clr          in   end-of-instruction from controller (ignored in FETCH)
//   instr_valid  in   program memory word on external bus is valid
//   mem_req      out  request instruction at address pc (high in FETCH)
//   pc           out  address of instruction being fetched/executed
//   T            out  timestep to controller
//   ir_en        out  qualifies controller IRin (FETCH and instr_valid)
//   busy         out  high in FETCH or EXEC
//   illegal      out  sticky: an instruction timed out without Clr
//   retired      out  wrapping count of completed or aborted instructions
// ============================================================================
module instr_sequencer #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              Clr,
    input  logic              instr_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        T,
    output logic              ir_en,
    output logic              busy,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_step_q;
    logic [1:0]          r_t;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_illegal;
    logic [CNT_W-1:0]    r_retired;
    logic                r_mem_req;
    logic                r_busy;

    logic                w_step_edge;
    logic                w_end_instr;
    logic                w_timeout;

    assign w_step_edge = step & ~r_step_q;
    // In EXEC the instruction ends either on Clr or by timing out at T=3.
    assign w_timeout   = (r_t == 2'd3) & ~Clr;
    assign w_end_instr = Clr | (r_t == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_step_q  <= 1'b0;
            r_t       <= 2'd0;
            r_pc      <= '0;
            r_illegal <= 1'b0;
            r_retired <= '0;
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // Step edges seen while busy are simply dropped, never queued.
            r_step_q <= step;
            case (r_state)
                S_IDLE: begin
                    r_t <= 2'd0;
                    if (run || w_step_edge) begin
                        r_state   <= S_FETCH;
                        r_mem_req <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (instr_valid) begin
                        r_state   <= S_EXEC;
                        r_t       <= 2'd1;
                        r_mem_req <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (w_end_instr) begin
                        r_t       <= 2'd0;
                        r_pc      <= r_pc + ADDR_W'(1);
                        r_retired <= r_retired + CNT_W'(1);
                        if (w_timeout) begin
                            r_illegal <= 1'b1;
                        end
                        if (run) begin
                            r_state   <= S_FETCH;
                            r_mem_req <= 1'b1;
                        end else begin
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                        end
                    end else begin
                        r_t <= r_t + 2'd1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_t       <= 2'd0;
                    r_mem_req <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req = r_mem_req;
    assign busy    = r_busy;
    assign pc      = r_pc;
    assign T       = r_t;
    assign illegal = r_illegal;
    assign retired = r_retired;
    // Only output that is not registered: IRin qualification follows the bus.
    assign ir_en   = (r_state == S_FETCH) & instr_valid;

endmodule
